// File: rtl/slink_crc16_multibyte.sv
// CRC-16/MCRF4XX engine taking NUM_BYTES bytes per beat, with sop/eop framing,
// a partial final beat, in-line compare against crc_rx, and registered results.
module slink_crc16_multibyte #(
  parameter int NUM_BYTES = 4,
  localparam int LB_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic                   valid,
  input  logic                   sop,
  input  logic                   eop,
  input  logic [NUM_BYTES*8-1:0] data,
  input  logic [LB_W-1:0]        last_bytes,
  input  logic                   check_en,
  input  logic [15:0]            crc_rx,
  output logic [15:0]            crc_out,
  output logic                   crc_valid,
  output logic                   crc_err,
  output logic [15:0]            byte_count,
  output logic                   busy,
  output logic                   proto_err
);

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [16:0] CNT_SAT  = 17'h10000;

  typedef enum logic [0:0] {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t      state_r, state_next_s;
  logic [15:0] acc_r, acc_next_s;
  logic [16:0] cnt_r, cnt_next_s;
  logic [4:0]  beat_len_s;
  logic [15:0] seed_s, beat_crc_s;
  logic [16:0] cnt_sum_s, cnt_sat_s;
  logic        restart_s, fin_s, perr_s;

  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int k = 0; k < 8; k++) begin
      if (c[0]) c = (c >> 1) ^ CRC_POLY;
      else      c = c >> 1;
    end
    return c;
  endfunction

  // Bytes at or beyond n are skipped so a partial eop beat leaves them out of the CRC.
  function automatic logic [15:0] crc_beat(input logic [15:0] seed,
                                           input logic [NUM_BYTES*8-1:0] d,
                                           input logic [4:0] n);
    logic [15:0] c;
    c = seed;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (5'(i) < n) c = crc_byte(c, d[i*8 +: 8]);
      else           c = c;
    end
    return c;
  endfunction

  // Beat length, seed and running byte count for the current beat.
  always_comb begin
    if (NUM_BYTES == 1)  beat_len_s = 5'd1;
    else if (eop)        beat_len_s = 5'(last_bytes) + 5'd1;
    else                 beat_len_s = 5'(NUM_BYTES);
    restart_s  = (state_r == IDLE) || sop;
    seed_s     = restart_s ? CRC_INIT : acc_r;
    beat_crc_s = crc_beat(seed_s, data, beat_len_s);
    cnt_sum_s  = (restart_s ? 17'd0 : cnt_r) + 17'(beat_len_s);
    cnt_sat_s  = (cnt_sum_s > CNT_SAT) ? CNT_SAT : cnt_sum_s;
  end

  // Framing next-state logic; a sop always restarts, even mid-packet.
  always_comb begin
    state_next_s = state_r;
    acc_next_s   = acc_r;
    cnt_next_s   = cnt_r;
    fin_s        = 1'b0;
    perr_s       = 1'b0;
    if (valid) begin
      case (state_r)
        IDLE: begin
          if (sop) begin
            if (eop) begin
              fin_s = 1'b1;
            end else begin
              state_next_s = IN_PKT;
              acc_next_s   = beat_crc_s;
              cnt_next_s   = cnt_sat_s;
            end
          end else begin
            perr_s = 1'b1;
          end
        end
        IN_PKT: begin
          perr_s = sop;
          if (eop) begin
            fin_s        = 1'b1;
            state_next_s = IDLE;
            acc_next_s   = CRC_INIT;
            cnt_next_s   = 17'd0;
          end else begin
            acc_next_s = beat_crc_s;
            cnt_next_s = cnt_sat_s;
          end
        end
        default: begin
          state_next_s = IDLE;
          acc_next_s   = CRC_INIT;
          cnt_next_s   = 17'd0;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      acc_r      <= CRC_INIT;
      cnt_r      <= 17'd0;
      crc_out    <= CRC_INIT;
      byte_count <= 16'd0;
      crc_valid  <= 1'b0;
      crc_err    <= 1'b0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
    end else if (init) begin
      state_r   <= IDLE;
      acc_r     <= CRC_INIT;
      cnt_r     <= 17'd0;
      crc_valid <= 1'b0;
      crc_err   <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      acc_r     <= acc_next_s;
      cnt_r     <= cnt_next_s;
      crc_valid <= fin_s;
      busy      <= (state_next_s == IN_PKT);
      proto_err <= perr_s;
      if (fin_s) begin
        crc_out    <= beat_crc_s;
        byte_count <= cnt_sat_s[16] ? 16'hFFFF : cnt_sat_s[15:0];
        crc_err    <= check_en && (beat_crc_s != crc_rx);
      end else begin
        crc_err <= crc_err;
      end
    end
  end

endmodule

// File: tb/tb_slink_crc16_multibyte.sv
// Directed bench for slink_crc16_multibyte: NUM_BYTES=4 main instance plus
// NUM_BYTES=1 and NUM_BYTES=8 instances for the "123456789" reference vector.
module tb_slink_crc16_multibyte;

  logic clk, reset, init, check_en;
  logic [15:0] crc_rx;

  logic        v4, s4, e4;
  logic [31:0] d4;
  logic [1:0]  lb4;
  logic [15:0] co4, bc4;
  logic        cv4, ce4, by4, pe4;

  logic        v1, s1, e1;
  logic [7:0]  d1;
  logic [0:0]  lb1;
  logic [15:0] co1, bc1;
  logic        cv1, ce1, by1, pe1;

  logic        v8, s8, e8;
  logic [63:0] d8;
  logic [2:0]  lb8;
  logic [15:0] co8, bc8;
  logic        cv8, ce8, by8, pe8;

  logic [7:0]  pat [24];
  int          tests, fails;

  slink_crc16_multibyte #(.NUM_BYTES(4)) dut4 (
    .clk(clk), .reset(reset), .init(init), .valid(v4), .sop(s4), .eop(e4),
    .data(d4), .last_bytes(lb4), .check_en(check_en), .crc_rx(crc_rx),
    .crc_out(co4), .crc_valid(cv4), .crc_err(ce4), .byte_count(bc4),
    .busy(by4), .proto_err(pe4));

  slink_crc16_multibyte #(.NUM_BYTES(1)) dut1 (
    .clk(clk), .reset(reset), .init(init), .valid(v1), .sop(s1), .eop(e1),
    .data(d1), .last_bytes(lb1), .check_en(check_en), .crc_rx(crc_rx),
    .crc_out(co1), .crc_valid(cv1), .crc_err(ce1), .byte_count(bc1),
    .busy(by1), .proto_err(pe1));

  slink_crc16_multibyte #(.NUM_BYTES(8)) dut8 (
    .clk(clk), .reset(reset), .init(init), .valid(v8), .sop(s8), .eop(e8),
    .data(d8), .last_bytes(lb8), .check_en(check_en), .crc_rx(crc_rx),
    .crc_out(co8), .crc_valid(cv8), .crc_err(ce8), .byte_count(bc8),
    .busy(by8), .proto_err(pe8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference: bytes LSB-first, byte 0 first.
  function automatic logic [15:0] crc_ref(input logic [31:0] w, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n * 8; i++) begin
      fb = c[0] ^ w[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) cyc();
  endtask

  task automatic b4(input logic s, input logic e, input logic [31:0] d, input logic [1:0] lb);
    v4 = 1'b1; s4 = s; e4 = e; d4 = d; lb4 = lb;
    cyc();
    v4 = 1'b0; s4 = 1'b0; e4 = 1'b0;
  endtask

  task automatic b1(input logic s, input logic e, input logic [7:0] d);
    v1 = 1'b1; s1 = s; e1 = e; d1 = d;
    cyc();
    v1 = 1'b0; s1 = 1'b0; e1 = 1'b0;
  endtask

  task automatic b8(input logic s, input logic e, input logic [63:0] d, input logic [2:0] lb);
    v8 = 1'b1; s8 = s; e8 = e; d8 = d; lb8 = lb;
    cyc();
    v8 = 1'b0; s8 = 1'b0; e8 = 1'b0;
  endtask

  task automatic pkt24(input logic ce, input logic [15:0] rx);
    logic [31:0] w;
    for (int i = 0; i < 6; i++) begin
      w = {pat[4*i+3], pat[4*i+2], pat[4*i+1], pat[4*i]};
      check_en = ce;
      crc_rx   = rx;
      b4(i == 0, i == 5, w, 2'd3);
      if (i == 0) begin
        chk("pkt24_busy_first", {31'd0, by4}, 32'd1);
        chk("pkt24_novalid_first", {31'd0, cv4}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] ch;
    logic [31:0] w1;
    tests = 0; fails = 0;
    pat = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7,
            8'h4F, 8'h82, 8'h78, 8'hC5, 8'h82, 8'hE0, 8'h8C, 8'h70,
            8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};
    reset = 1'b1; init = 1'b0; check_en = 1'b0; crc_rx = 16'h0000;
    v4 = 1'b0; s4 = 1'b0; e4 = 1'b0; d4 = 32'd0; lb4 = 2'd0;
    v1 = 1'b0; s1 = 1'b0; e1 = 1'b0; d1 = 8'd0; lb1 = 1'b0;
    v8 = 1'b0; s8 = 1'b0; e8 = 1'b0; d8 = 64'd0; lb8 = 3'd0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    chk("rst_crc_out", {16'd0, co4}, 32'hFFFF);
    chk("rst_byte_count", {16'd0, bc4}, 32'd0);
    chk("rst_crc_valid", {31'd0, cv4}, 32'd0);
    chk("rst_crc_err", {31'd0, ce4}, 32'd0);
    chk("rst_busy", {31'd0, by4}, 32'd0);
    chk("rst_proto_err", {31'd0, pe4}, 32'd0);

    pkt24(1'b0, 16'h0000);
    chk("p24_valid", {31'd0, cv4}, 32'd1);
    chk("p24_crc", {16'd0, co4}, 32'hE569);
    chk("p24_count", {16'd0, bc4}, 32'd24);
    chk("p24_err", {31'd0, ce4}, 32'd0);
    chk("p24_busy_after", {31'd0, by4}, 32'd0);
    cyc();
    chk("p24_valid_pulse", {31'd0, cv4}, 32'd0);
    chk("p24_crc_hold", {16'd0, co4}, 32'hE569);

    b4(1'b1, 1'b0, 32'h34333231, 2'd0); gap();
    b4(1'b0, 1'b0, 32'h38373635, 2'd0); gap();
    b4(1'b0, 1'b1, 32'h00000039, 2'd0);
    chk("p9_valid", {31'd0, cv4}, 32'd1);
    chk("p9_crc", {16'd0, co4}, 32'h6F91);
    chk("p9_count", {16'd0, bc4}, 32'd9);

    for (int i = 0; i < 9; i++) begin
      ch = 8'h31 + 8'(i);
      b1(i == 0, i == 8, ch);
      if (i != 8) gap();
    end
    chk("nb1_valid", {31'd0, cv1}, 32'd1);
    chk("nb1_crc", {16'd0, co1}, 32'h6F91);
    chk("nb1_count", {16'd0, bc1}, 32'd9);

    b8(1'b1, 1'b0, 64'h3837363534333231, 3'd0); gap();
    b8(1'b0, 1'b1, 64'h0000000000000039, 3'd0);
    chk("nb8_valid", {31'd0, cv8}, 32'd1);
    chk("nb8_crc", {16'd0, co8}, 32'h6F91);
    chk("nb8_count", {16'd0, bc8}, 32'd9);

    pkt24(1'b1, 16'hE569);
    chk("chk_match_err", {31'd0, ce4}, 32'd0);
    pkt24(1'b1, 16'hE568);
    chk("chk_mismatch_err", {31'd0, ce4}, 32'd1);
    cyc();
    chk("chk_err_hold", {31'd0, ce4}, 32'd1);
    pkt24(1'b0, 16'hE568);
    chk("chk_disabled_err", {31'd0, ce4}, 32'd0);
    check_en = 1'b0;

    b4(1'b0, 1'b0, 32'h12345678, 2'd3);
    chk("idle_nosop_perr", {31'd0, pe4}, 32'd1);
    chk("idle_nosop_busy", {31'd0, by4}, 32'd0);
    chk("idle_nosop_valid", {31'd0, cv4}, 32'd0);
    cyc();
    chk("idle_perr_pulse", {31'd0, pe4}, 32'd0);

    b4(1'b1, 1'b0, 32'hAAAAAAAA, 2'd3);
    chk("junk_sop_perr", {31'd0, pe4}, 32'd0);
    b4(1'b1, 1'b0, 32'h34333231, 2'd0);
    chk("midsop_perr", {31'd0, pe4}, 32'd1);
    chk("midsop_busy", {31'd0, by4}, 32'd1);
    b4(1'b0, 1'b0, 32'h38373635, 2'd0);
    chk("midsop_perr_pulse", {31'd0, pe4}, 32'd0);
    b4(1'b0, 1'b1, 32'h00000039, 2'd0);
    chk("midsop_crc", {16'd0, co4}, 32'h6F91);
    chk("midsop_count", {16'd0, bc4}, 32'd9);

    pkt24(1'b1, 16'hE568);
    chk("init_pre_err", {31'd0, ce4}, 32'd1);
    b4(1'b1, 1'b0, 32'h11111111, 2'd3);
    b4(1'b0, 1'b0, 32'h22222222, 2'd3);
    init = 1'b1;
    cyc();
    init = 1'b0;
    chk("init_busy", {31'd0, by4}, 32'd0);
    chk("init_valid", {31'd0, cv4}, 32'd0);
    chk("init_err_clear", {31'd0, ce4}, 32'd0);
    chk("init_crc_hold", {16'd0, co4}, 32'hE569);
    chk("init_count_hold", {16'd0, bc4}, 32'd24);
    pkt24(1'b0, 16'h0000);
    chk("post_init_crc", {16'd0, co4}, 32'hE569);

    w1 = 32'hDEADBEEF;
    b4(1'b1, 1'b1, w1, 2'd3);
    chk("b2b_single_valid", {31'd0, cv4}, 32'd1);
    chk("b2b_single_crc", {16'd0, co4}, {16'd0, crc_ref(w1, 4)});
    chk("b2b_single_count", {16'd0, bc4}, 32'd4);
    pkt24(1'b0, 16'h0000);
    chk("b2b_p24_valid", {31'd0, cv4}, 32'd1);
    chk("b2b_p24_crc", {16'd0, co4}, 32'hE569);
    chk("b2b_p24_count", {16'd0, bc4}, 32'd24);
    b4(1'b1, 1'b1, w1, 2'd1);
    chk("partial2_crc", {16'd0, co4}, {16'd0, crc_ref(w1, 2)});
    chk("partial2_count", {16'd0, bc4}, 32'd2);

    b4(1'b1, 1'b0, 32'h33333333, 2'd3);
    b4(1'b0, 1'b0, 32'h44444444, 2'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst_crc_out", {16'd0, co4}, 32'hFFFF);
    chk("arst_count", {16'd0, bc4}, 32'd0);
    chk("arst_valid", {31'd0, cv4}, 32'd0);
    chk("arst_busy", {31'd0, by4}, 32'd0);
    chk("arst_perr", {31'd0, pe4}, 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    b4(1'b0, 1'b1, 32'h55555555, 2'd3);
    chk("arst_lost_valid", {31'd0, cv4}, 32'd0);
    chk("arst_lost_perr", {31'd0, pe4}, 32'd1);
    chk("arst_lost_crc", {16'd0, co4}, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slink_crc16_multibyte.md
# slink_crc16_multibyte

Multi-byte-per-cycle CRC-16/MCRF4XX engine with packet framing, partial final beat and in-line check mode. It sits on the S-Link packet datapath after lane deskew (RX check) or before lane distribution (TX generate). It accumulates CRC over NUM_BYTES bytes per cycle between sop and eop and presents a registered final CRC, byte count and compare result one cycle after eop. It is the parametrised successor of the single-byte CRC computer.

## Interface
- NUM_BYTES, 4, bytes accepted per beat; legal values 1, 2, 4, 8.
- LB_W, derived = max(1, clog2(NUM_BYTES)), width of last_bytes.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- init  in  1  synchronous clear to IDLE; priority over all other inputs.
- valid  in  1  data beat present.
- sop  in  1  first beat of packet; qualified by valid.
- eop  in  1  last beat of packet; qualified by valid.
- data  in  NUM_BYTES*8  payload; byte 0 = data[7:0] is processed first.
- last_bytes  in  LB_W  on an eop beat, number of valid bytes minus 1 (bytes 0..last_bytes). Ignored on other beats.
- check_en  in  1  sampled on the eop beat; enables the compare against crc_rx.
- crc_rx  in  16  expected CRC, sampled on the eop beat.
- crc_out  out  16  final CRC of the last completed packet.
- crc_valid  out  1  one-cycle pulse when crc_out updates.
- crc_err  out  1  compare mismatch, valid with crc_valid.
- byte_count  out  16  bytes in the last completed packet; saturates at 16'hFFFF.
- busy  out  1  high in IN_PKT.
- proto_err  out  1  one-cycle framing-error pulse.

## Operation
- Algorithm: reflected polynomial 0x8408, init 16'hFFFF, no output XOR, no reflection of the result.
- Per-byte step: c ^= byte, then 8× (c = c[0] ? (c>>1)^16'h8408 : c>>1).
- A beat chains the step over bytes 0..n-1 combinationally, with one register stage per beat. n = NUM_BYTES, or last_bytes+1 on an eop beat.
- Accumulator acc (16 b) and counter cnt (17 b internal) are separate from the output registers.
- States:
  - IDLE: acc = FFFF, cnt = 0.
  - IN_PKT: packet in progress.
- IDLE transitions:
  - valid & sop & !eop → IN_PKT; acc = step(FFFF, beat); cnt = NUM_BYTES.
  - valid & sop & eop → single-beat packet; finalise; stay IDLE.
  - valid & !sop → beat ignored; proto_err pulse.
- IN_PKT transitions:
  - valid & !sop & !eop → acc = step(acc, beat); cnt += NUM_BYTES.
  - valid & eop & !sop → finalise with step(acc, partial beat) → IDLE.
  - valid & sop → proto_err pulse; current packet is discarded without crc_valid; restart with this beat as a new sop (same as the IDLE sop rules).
  - !valid → hold acc and cnt; stalls of any length are legal.
- Finalise:
  - crc_out ← final CRC.
  - byte_count ← min(total bytes, FFFF).
  - crc_err ← check_en & (final CRC != crc_rx).
  - crc_valid pulses.
- init: state → IDLE, acc → FFFF, cnt → 0, no crc_valid. crc_out and byte_count hold; crc_err clears.
- last_bytes values ≥ NUM_BYTES cannot occur for power-of-two NUM_BYTES. For NUM_BYTES = 1, last_bytes is ignored.

## Timing
- Reset values:
  - crc_out = 16'hFFFF, byte_count = 0.
  - crc_valid = 0, crc_err = 0, busy = 0, proto_err = 0.
  - State IDLE, acc = FFFF.
- Latency: eop beat at cycle N → crc_valid, crc_out, crc_err and byte_count present at cycle N+1.
- Throughput: one beat per cycle, including back-to-back packets (eop at N, sop at N+1) with no bubble.
- crc_out, byte_count and crc_err hold until the next finalise or init; crc_err also clears on the next crc_valid without error.
- busy is registered and reflects state after the clock edge.
- proto_err is registered and pulses at cycle N+1 for the offending beat at N.
- Asynchronous reset mid-packet: the packet is lost, with no crc_valid after release. The first beat after release must carry sop.

## Test plan
- NUM_BYTES=4, 24-byte pattern FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01 sent as 6 beats, eop with last_bytes=3 → crc_out=16'hE569, byte_count=24, crc_valid one cycle after eop.
- ASCII "123456789" as 3 beats, eop beat last_bytes=0, random valid gaps inserted → crc_out=16'h6F91, byte_count=9. Repeat with NUM_BYTES=1 and NUM_BYTES=8 → same result.
- Check mode on the 24-byte pattern:
  - check_en=1, crc_rx=16'hE569 → crc_err=0.
  - check_en=1, crc_rx=16'hE568 → crc_err=1.
  - check_en=0, crc_rx=16'hE568 → crc_err=0.
- Framing errors:
  - valid without sop in IDLE → proto_err pulse, no state change.
  - sop mid-packet → proto_err pulse; the following "123456789" packet still yields 16'h6F91.
- init asserted two beats into a packet, then the 24-byte packet sent → no crc_valid for the aborted packet; next result is 16'hE569. Async reset mid-packet → all outputs at reset values.
- Back-to-back packets: single-beat sop&eop packet immediately followed by the 24-byte packet → crc_valid on two consecutive finalise cycles with matching model values, byte_count 4 then 24.
